// File: rtl/digit_entry.sv
// digit_entry
// Push-button front end of the cube-root calculator. Two active-low keys
// build a DIGITS-wide decimal operand one position at a time; a rising
// SWITCH converts the BCD digits to binary and strobes `value` out.
//
// Optional feature macro: DIGIT_ENTRY_DEBOUNCE_EN
//   defined   : each key is debounced (DEBOUNCE_CYCLES stable samples)
//   undefined : the synchronized key level drives the press detector
//
// Ports
//   on3           in   system clock, rising edge
//   RESET         in   synchronous active-high reset
//   KEY_DIGIT     in   active-low, press bumps the digit under the cursor
//   KEY_INCREMENT in   active-low, press advances the cursor (saturating)
//   SWITCH        in   0 = entry, 1 = calculate
//   bcd           out  entered digits, position t has weight 10^t
//   digit_set     out  bit t = position t has been touched
//   cursor        out  current position
//   value         out  binary operand (zero-extended)
//   value_valid   out  one-cycle strobe when `value` updates
module digit_entry #(
  parameter int DIGITS          = 6,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   on3,
  input  logic                   RESET,
  input  logic                   KEY_DIGIT,
  input  logic                   KEY_INCREMENT,
  input  logic                   SWITCH,
  output logic [DIGITS-1:0][3:0] bcd,
  output logic [DIGITS-1:0]      digit_set,
  output logic [2:0]             cursor,
  output logic [31:0]            value,
  output logic                   value_valid
);

  localparam int ACC_W = 20;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_CONVERT,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------
  // Key path: synchronizer -> (optional debouncer) -> falling-edge
  // detector. Index 0 is KEY_DIGIT, index 1 is KEY_INCREMENT.
  // ---------------------------------------------------------------
  logic [1:0] key_raw;
  logic [1:0] key_press;

  assign key_raw = {KEY_INCREMENT, KEY_DIGIT};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic sync1_reg;
      logic sync2_reg;
      logic db_level;
      logic prev_reg;

      always_ff @(posedge on3) begin
        if (RESET) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
        end
      end

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CNT_W-1:0] cnt_reg;

      // Counts consecutive samples that disagree with the accepted level;
      // the level flips on the DEBOUNCE_CYCLES-th one.
      always_ff @(posedge on3) begin
        if (RESET) begin
          db_level <= 1'b1;
          cnt_reg  <= '0;
        end else if (sync2_reg == db_level) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= sync2_reg;
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
`else
      // Debounce length is irrelevant when the debouncer is bypassed.
      logic unused_cfg;
      assign unused_cfg = (DEBOUNCE_CYCLES > 0);
      assign db_level   = sync2_reg;
`endif

      always_ff @(posedge on3) begin
        if (RESET) prev_reg <= 1'b1;
        else       prev_reg <= db_level;
      end

      // 1 -> 0 of the accepted level is one press; a held key stays low.
      assign key_press[gi] = prev_reg & ~db_level;
    end
  endgenerate

  logic digit_press;
  logic inc_press;
  assign digit_press = key_press[0];
  assign inc_press   = key_press[1];

  // ---------------------------------------------------------------
  // SWITCH path: synchronizer plus edge detector.
  // ---------------------------------------------------------------
  logic sw_sync1_reg;
  logic sw_sync2_reg;
  logic sw_prev_reg;
  logic sw_rise;
  logic sw_fall;

  always_ff @(posedge on3) begin
    if (RESET) begin
      sw_sync1_reg <= 1'b0;
      sw_sync2_reg <= 1'b0;
      sw_prev_reg  <= 1'b0;
    end else begin
      sw_sync1_reg <= SWITCH;
      sw_sync2_reg <= sw_sync1_reg;
      sw_prev_reg  <= sw_sync2_reg;
    end
  end

  assign sw_rise = sw_sync2_reg & ~sw_prev_reg;
  assign sw_fall = ~sw_sync2_reg & sw_prev_reg;

  // ---------------------------------------------------------------
  // Entry / conversion FSM
  // ---------------------------------------------------------------
  state_t                  state_reg,  state_next;
  logic [DIGITS-1:0][3:0]  bcd_reg,    bcd_next;
  logic [DIGITS-1:0]       set_reg,    set_next;
  logic [2:0]              cursor_reg, cursor_next;
  logic [2:0]              index_reg,  index_next;
  logic [ACC_W-1:0]        acc_reg,    acc_next;
  logic [ACC_W-1:0]        value_reg,  value_next;
  logic                    valid_reg,  valid_next;
  logic [ACC_W-1:0]        acc_step;
  logic [3:0]              conv_digit;

  always_ff @(posedge on3) begin
    if (RESET) begin
      state_reg  <= ST_ENTRY;
      bcd_reg    <= '0;
      set_reg    <= '0;
      cursor_reg <= '0;
      index_reg  <= '0;
      acc_reg    <= '0;
      value_reg  <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      bcd_reg    <= bcd_next;
      set_reg    <= set_next;
      cursor_reg <= cursor_next;
      index_reg  <= index_next;
      acc_reg    <= acc_next;
      value_reg  <= value_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bcd_next    = bcd_reg;
    set_next    = set_reg;
    cursor_next = cursor_reg;
    index_next  = index_reg;
    acc_next    = acc_reg;
    value_next  = value_reg;
    valid_next  = 1'b0;

    // Untouched positions contribute zero regardless of stored BCD.
    conv_digit = set_reg[index_reg] ? bcd_reg[index_reg] : 4'd0;
    acc_step   = acc_reg * ACC_W'(10) + ACC_W'(conv_digit);

    case (state_reg)
      ST_ENTRY: begin
        // Digit update uses the pre-advance cursor when both keys fire.
        if (digit_press) begin
          if (!set_reg[cursor_reg]) begin
            bcd_next[cursor_reg] = 4'd0;
            set_next[cursor_reg] = 1'b1;
          end else if (bcd_reg[cursor_reg] == 4'd9) begin
            bcd_next[cursor_reg] = 4'd0;
          end else begin
            bcd_next[cursor_reg] = bcd_reg[cursor_reg] + 4'd1;
          end
        end
        if (inc_press && (cursor_reg != 3'(DIGITS - 1))) begin
          cursor_next = cursor_reg + 3'd1;
        end
        if (sw_rise) begin
          state_next = ST_CONVERT;
          acc_next   = '0;
          index_next = 3'(DIGITS - 1);
        end
      end

      ST_CONVERT: begin
        if (sw_fall) begin
          // Abort: entry is discarded, previous value is kept, no strobe.
          state_next  = ST_ENTRY;
          bcd_next    = '0;
          set_next    = '0;
          cursor_next = '0;
        end else if (index_reg == 3'd0) begin
          value_next = acc_step;
          valid_next = 1'b1;
          state_next = ST_DONE;
        end else begin
          acc_next   = acc_step;
          index_next = index_reg - 3'd1;
        end
      end

      ST_DONE: begin
        if (sw_fall) begin
          state_next  = ST_ENTRY;
          bcd_next    = '0;
          set_next    = '0;
          cursor_next = '0;
        end
      end

      default: begin
        state_next = ST_ENTRY;
      end
    endcase
  end

  assign bcd         = bcd_reg;
  assign digit_set   = set_reg;
  assign cursor      = cursor_reg;
  assign value       = {{(32 - ACC_W){1'b0}}, value_reg};
  assign value_valid = valid_reg;

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry. A behavioural model tracks the
// operand as plain integer digits; conversions push the expected value and
// strobe cycle into a queue that an independent monitor drains whenever
// value_valid is seen. Directed scenarios are followed by random rounds.
module tb_digit_entry;

  localparam int DIGITS = 6;
  localparam int DB     = 4;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
  localparam int MIN_LOW = DB;   // shortest low pulse the key path accepts
`else
  localparam int MIN_LOW = 1;
`endif
  localparam int GAP  = DB + 6;  // released time after every press
  localparam int HOLD = DB + 2;  // standard press length

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_digit = 1'b1;
  logic key_inc = 1'b1;
  logic sw = 1'b0;
  logic [DIGITS-1:0][3:0] bcd;
  logic [DIGITS-1:0]      digit_set;
  logic [2:0]             cursor;
  logic [31:0]            value;
  logic                   value_valid;

  always #5 clk = ~clk;

  digit_entry #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DB)) dut (
    .on3          (clk),
    .RESET        (rst),
    .KEY_DIGIT    (key_digit),
    .KEY_INCREMENT(key_inc),
    .SWITCH       (sw),
    .bcd          (bcd),
    .digit_set    (digit_set),
    .cursor       (cursor),
    .value        (value),
    .value_valid  (value_valid)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint      v;
    int unsigned at;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- reference model ----------------
  int     m_bcd[DIGITS];
  bit     m_set[DIGITS];
  int     m_cur;
  longint m_value;

  function automatic void model_clear_entry();
    for (int t = 0; t < DIGITS; t++) begin
      m_bcd[t] = 0;
      m_set[t] = 1'b0;
    end
    m_cur = 0;
  endfunction

  function automatic void model_event(bit dig, bit inc);
    if (dig) begin
      if (!m_set[m_cur]) begin
        m_set[m_cur] = 1'b1;
        m_bcd[m_cur] = 0;
      end else begin
        m_bcd[m_cur] = (m_bcd[m_cur] + 1) % 10;
      end
    end
    if (inc && m_cur < DIGITS - 1) m_cur = m_cur + 1;
  endfunction

  function automatic longint model_operand();
    longint v = 0;
    longint w = 1;
    for (int t = 0; t < DIGITS; t++) begin
      if (m_set[t]) v = v + m_bcd[t] * w;
      w = w * 10;
    end
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_state(input string tag);
    logic [DIGITS*4-1:0] eb;
    logic [DIGITS-1:0]   es;
    logic [DIGITS*4-1:0] ab;
    for (int t = 0; t < DIGITS; t++) begin
      eb[t*4 +: 4] = 4'(m_bcd[t]);
      es[t]        = m_set[t];
    end
    ab = bcd;
    check({tag, "_bcd"}, longint'(ab), longint'(eb));
    check({tag, "_digit_set"}, longint'(digit_set), longint'(es));
    check({tag, "_cursor"}, longint'(cursor), longint'(m_cur));
    check({tag, "_value"}, longint'(value), m_value);
  endtask

  // ---------------- monitor ----------------
  logic [31:0] prev_value = '0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && value != prev_value) begin
      check("value_change_strobe", longint'(value_valid), 1);
    end
    if (value_valid) begin
      check("valid_single_cycle", longint'(prev_valid), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=%0d required=none", value);
      end else begin
        e = exp_q.pop_front();
        check("strobe_value", longint'(value), e.v);
        check("strobe_cycle", longint'(cyc), longint'(e.at));
      end
    end
    prev_valid = value_valid;
    prev_value = value;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit dig, input bit inc, input int low);
    if (dig) key_digit = 1'b0;
    if (inc) key_inc = 1'b0;
    tick(low);
    key_digit = 1'b1;
    key_inc   = 1'b1;
    tick(GAP);
    if (low >= MIN_LOW) model_event(dig, inc);
  endtask

  task automatic convert_and_release(input string tag);
    exp_t e;
    sw     = 1'b1;
    e.v    = model_operand();
    e.at   = cyc + DIGITS + 3;
    exp_q.push_back(e);
    m_value = e.v;
    tick(DIGITS + 8);
    check_state({tag, "_done"});
    sw = 1'b0;
    tick(4);
    model_clear_entry();
    check_state({tag, "_cleared"});
  endtask

  initial begin
    int n;
    int kind;
    model_clear_entry();
    m_value = 0;

    // Reset
    tick(2);
    check_state("reset");
    check("reset_valid", longint'(value_valid), 0);
    rst = 1'b0;
    tick(2);

    // Digit wrap and cursor saturation
    for (int i = 0; i < 11; i++) press(1'b1, 1'b0, HOLD);
    check("wrap_bcd0", longint'(bcd[0]), 0);
    for (int i = 0; i < 8; i++) press(1'b0, 1'b1, HOLD);
    check("saturate_cursor", longint'(cursor), 5);
    check_state("wrap");
    convert_and_release("wrap_conv");

    // Entry and conversion: 321
    press(1'b1, 1'b0, HOLD); press(1'b1, 1'b0, HOLD);
    press(1'b0, 1'b1, HOLD);
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, HOLD);
    press(1'b0, 1'b1, HOLD);
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, HOLD);
    check("entry_cursor", longint'(cursor), 2);
    check_state("entry");
    convert_and_release("conv321");
    check("value_321", longint'(value), 321);

    // Abort a few cycles into conversion
    press(1'b1, 1'b0, HOLD); press(1'b1, 1'b0, HOLD);
    sw = 1'b1;
    tick(4);
    sw = 1'b0;
    tick(10);
    model_clear_entry();
    check_state("abort");
    check("abort_value", longint'(value), 321);

    // All nines
    for (int t = 0; t < DIGITS; t++) begin
      for (int i = 0; i < 10; i++) press(1'b1, 1'b0, HOLD);
      press(1'b0, 1'b1, HOLD);
    end
    convert_and_release("nines");
    check("value_999999", longint'(value), 999999);

    // Short glitches then a long hold
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 3);
    check_state("glitch");
    press(1'b1, 1'b0, 10);
    check_state("hold");
    convert_and_release("glitch_conv");

    // Both keys in the same cycle at cursor 0
    press(1'b1, 1'b1, HOLD);
    check("both_bcd0", longint'(bcd[0]), 0);
    check("both_set0", longint'(digit_set[0]), 1);
    check("both_cursor", longint'(cursor), 1);
    check_state("both");

    // Reset during conversion
    press(1'b1, 1'b0, HOLD);
    sw = 1'b1;
    tick(5);
    rst = 1'b1;
    sw  = 1'b0;
    tick(1);
    model_clear_entry();
    m_value = 0;
    check_state("rst_conv");
    check("rst_conv_valid", longint'(value_valid), 0);
    tick(1);
    rst = 1'b0;
    tick(14);
    check_state("rst_after");

    // Random rounds
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 4);
        press(kind != 1, kind == 1 || kind == 4, $urandom_range(1, DB + 3));
      end
      check_state($sformatf("rand%0d", r));
      convert_and_release($sformatf("rand%0d_conv", r));
    end

    tick(20);
    check("pending_strobes", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_entry.md
# digit_entry

Front-end input stage of the cube-root calculator. Turns the two active-low push buttons (KEY_DIGIT, KEY_INCREMENT) into a six-digit decimal operand. Exposes per-digit BCD and cursor position so the display stage can show the entry in progress. When SWITCH rises, it converts the BCD digits to binary and presents `value` to the calculation stage with a one-cycle valid strobe.

## Interface
- DIGITS, 6: number of decimal positions; position t has weight 10^t.
- DEBOUNCE_CYCLES, 16: consecutive stable samples required before a key level is accepted.
- on3  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- KEY_DIGIT  in  1  active-low; each accepted press increments the digit under the cursor.
- KEY_INCREMENT  in  1  active-low; each accepted press advances the cursor.
- SWITCH  in  1  0 = entry mode, 1 = calculate.
- bcd  out  [DIGITS-1:0][3:0]  entered digits.
- digit_set  out  DIGITS  bit t = position t has been touched.
- cursor  out  3  current position, 0..DIGITS-1.
- value  out  32  binary operand, zero-extended (max 999999).
- value_valid  out  1  one-cycle strobe when `value` updates.

## Operation
- Reset values:
  - bcd, digit_set, cursor, value and value_valid are 0.
  - State is ENTRY.
  - Sync and debounce registers read as released (1).
  - SWITCH synchronizer reads 0.
- Key path:
  - Each key passes through a 2-flop synchronizer, then the debouncer.
  - A debounced 1→0 transition produces a single internal press event.
  - Holding a key produces exactly one event.
- SWITCH path: 2-flop synchronizer followed by an edge detector.
- State ENTRY:
  - Digit event with digit_set[cursor]=0: set bcd[cursor]=0 and digit_set[cursor]=1.
  - Digit event otherwise: bcd[cursor] = (bcd[cursor]==9) ? 0 : bcd[cursor]+1.
  - Increment event: cursor = min(cursor+1, DIGITS-1). The cursor saturates and never wraps.
  - Both events in the same cycle: the digit update applies to the old cursor, then the cursor advances.
  - Synchronized SWITCH rising edge → CONVERT with acc=0 and index=DIGITS-1.
- State CONVERT:
  - One digit per cycle: acc = acc*10 + (digit_set[index] ? bcd[index] : 0), then index decrements.
  - After index 0 is consumed: value=acc, value_valid=1 for one cycle, go to DONE.
  - Key events are ignored.
  - Synchronized SWITCH falling → abort to ENTRY with bcd, digit_set and cursor cleared. `value` is unchanged and no strobe is issued.
- State DONE:
  - Holds while SWITCH is 1; key events are ignored.
  - SWITCH falling → ENTRY with bcd, digit_set and cursor cleared. `value` is retained.
- Arithmetic:
  - acc is 20 bits; it cannot overflow for DIGITS=6.
  - `value` upper 12 bits are always 0.
- RESET in any state overrides everything in the same edge and restores the reset values.

## Timing
- Key press to bcd/cursor update:
  - With the debounce macro defined: DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the key low, given a stable press.
  - With the macro undefined: 3 edges.
- SWITCH rise to value_valid:
  - value_valid is high during the cycle following edge DIGITS+3, counted from the first edge sampling SWITCH=1.
  - For DIGITS=6 that is 9 edges.
- value_valid is never high for two consecutive cycles.
- `value` changes only on the edge that raises value_valid.
- Release time is unconstrained; re-press is accepted once the debounced level has returned to 1.

## Configuration
- DIGIT_ENTRY_DEBOUNCE_EN defined:
  - Each key has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - Any differing sample resets the counter.
- Undefined:
  - The debouncer is removed; the synchronized level feeds the edge detector directly.
  - Every synchronized 1→0 transition is a press. Used for fast simulation.

## Test plan
- Reset: RESET high 2 cycles with keys released → bcd=0, digit_set=0, cursor=0, value=0, value_valid=0.
- Entry and conversion (macro off):
  - Stimulus: DIGIT×2, INC, DIGIT×3, INC, DIGIT×4, then SWITCH=1.
  - Response: bcd[0]=1, bcd[1]=2, bcd[2]=3, cursor=2. value=321 with a single value_valid pulse 9 edges after the SWITCH sample.
- Digit wrap and cursor saturation:
  - 11 DIGIT presses → bcd[0]=0.
  - 8 INC presses → cursor=5.
  - All six digits set to 9 → value=999999.
- Bounce rejection (macro on, DEBOUNCE_CYCLES=4):
  - 3-cycle low glitches on KEY_DIGIT → no bcd change.
  - A 10-cycle hold → exactly one increment.
- Abort: drop SWITCH 3 cycles into CONVERT → no value_valid, value keeps its prior 321, bcd/digit_set/cursor cleared, state ENTRY.
- Simultaneous events and reset mid-operation:
  - DIGIT and INC accepted in the same cycle at cursor 0 → bcd[0]=0, digit_set[0]=1, cursor=1.
  - RESET asserted during CONVERT → all outputs 0 on the next edge, no strobe.
